decoder_pipe: RTL and testbench
===============================

DECODER_PIPE -- requirements
Module: decoder_pipe

Interface
REQ-001 Parameter SEL_W, default 5, width of the binary select.
REQ-002 Parameter NUM_OUT, default 32, number of decoded output lines; legal range 2..2^SEL_W.
REQ-003 Parameter CNT_W, default 8, width of the error counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  select word present on in_sel.
REQ-007 in_ready  output  1  block can accept a select word this cycle.
REQ-008 in_sel  input  SEL_W  binary select value.
REQ-009 in_mode  input  2  decode mode, sampled with in_sel: 00 one-hot, 01 thermometer, 10 active-low one-hot, 11 reserved.
REQ-010 out_valid  output  1  decoded word present on out_vec.
REQ-011 out_ready  input  1  consumer accepts out_vec this cycle.
REQ-012 out_vec  output  NUM_OUT  decoded word.
REQ-013 out_err  output  1  current out_vec came from an illegal select or mode.
REQ-014 err_sticky  output  1  an illegal transaction has been accepted since reset or clear.
REQ-015 err_count  output  CNT_W  saturating count of illegal transactions accepted.
REQ-016 err_clr  input  1  synchronous clear of err_sticky and err_count.

Function
REQ-017 Input transfer occurs when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-018 Storage is a 2-entry FIFO of {decoded word, err bit}; the entry is decoded at acceptance, not at output.
REQ-019 in_ready = 1 when the FIFO holds fewer than 2 entries; it depends on registered state only, never combinationally on out_ready.
REQ-020 out_valid = 1 when the FIFO holds at least 1 entry; out_vec/out_err show the oldest entry.
REQ-021 Latency: a word accepted at edge N is visible on out_vec after edge N (1 cycle) when the FIFO was empty.
REQ-022 Simultaneous input and output transfer with 1 entry held: occupancy stays 1, the new word follows the old one.
REQ-023 Simultaneous transfers with 2 entries held cannot occur, because in_ready = 0.
REQ-024 While out_valid && !out_ready, out_vec and out_err hold stable.
REQ-025 Mode 00: bit i = 1 iff in_sel == i; all other bits 0.
REQ-026 Mode 01: bit i = 1 iff i <= in_sel (bits 0..in_sel set).
REQ-027 Mode 10: bitwise inverse of the mode 00 result.
REQ-028 Illegal transaction: in_sel >= NUM_OUT, or in_mode == 11.
REQ-029 For an illegal transaction, the stored word is all zeros in modes 00/01/11 and all ones in mode 10, and the err bit is 1.
REQ-030 Each accepted illegal transaction sets err_sticky and increments err_count, which saturates at 2^CNT_W-1 with no wrap.
REQ-031 err_clr has priority over a same-cycle increment: both err_sticky and err_count go to 0.
REQ-032 Data read/write pointers wrap modulo 2.

Reset
REQ-033 Reset asserted: in_ready=1, out_valid=0, out_vec=0, out_err=0, err_sticky=0, err_count=0, FIFO empty.
REQ-034 Reset mid-operation discards all held entries, with no output transfer completing in that cycle.
REQ-035 The first transfer is accepted on the first rising edge after reset deasserts.

Verification
REQ-036 After reset, in_sel=5, mode 00, out_ready=1 -> next cycle out_vec=32'h0000_0020, out_err=0.
REQ-037 in_sel=3, mode 01 -> out_vec=32'h0000_000F; in_sel=3, mode 10 -> out_vec=32'hFFFF_FFF7.
REQ-038 NUM_OUT=20, in_sel=25, mode 00 -> out_vec=0, out_err=1, err_sticky=1, err_count=1; then err_clr=1 -> both 0.
REQ-039 out_ready=0, three back-to-back words (sel 1, 2, 3) -> in_ready=0 after 2 accepted; release out_ready -> outputs 0x2, 0x4, then 0x8 in order, none lost or duplicated.
REQ-040 CNT_W=2, 5 illegal transactions -> err_count sticks at 3.
REQ-041 reset pulsed with 2 entries held -> out_valid=0 and in_ready=1 immediately (asynchronously), err_count=0.

Source files
------------

// File: rtl/decoder_pipe.sv
// decoder_pipe: binary select decoder (one-hot / thermometer / active-low
// one-hot) feeding a 2-entry valid/ready FIFO, with sticky error flag and a
// saturating count of illegal transactions.
module decoder_pipe #(
   parameter int unsigned SEL_W   = 5,
   parameter int unsigned NUM_OUT = 32,
   parameter int unsigned CNT_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [SEL_W-1:0]   in_sel,
   input  logic [1:0]         in_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NUM_OUT-1:0] out_vec,
   output logic               out_err,
   output logic               err_sticky,
   output logic [CNT_W-1:0]   err_count,
   input  logic               err_clr
);

   localparam logic [1:0] MODE_ONEHOT = 2'b00;
   localparam logic [1:0] MODE_THERMO = 2'b01;
   localparam logic [1:0] MODE_INV    = 2'b10;

   // FIFO occupancy
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } occ_e;

   occ_e state_q, state_d;

   logic [NUM_OUT-1:0] mem_vec_q [2];
   logic [NUM_OUT-1:0] mem_vec_d [2];
   logic               mem_err_q [2];
   logic               mem_err_d [2];
   logic               wr_ptr_q, wr_ptr_d;
   logic               rd_ptr_q, rd_ptr_d;

   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic [NUM_OUT-1:0] out_vec_q, out_vec_d;
   logic               out_err_q, out_err_d;
   logic               err_sticky_q, err_sticky_d;
   logic [CNT_W-1:0]   err_count_q, err_count_d;

   logic               push_c;
   logic               pop_c;
   logic               dec_legal_c;
   logic [NUM_OUT-1:0] dec_one_c;
   logic [NUM_OUT-1:0] dec_vec_c;

   assign push_c = in_valid && in_ready_q;
   assign pop_c  = out_valid_q && out_ready;

   // Decode the incoming select at acceptance time
   always_comb begin
      dec_legal_c = (32'(in_sel) < NUM_OUT) && (in_mode != 2'b11);
      dec_one_c   = NUM_OUT'(1) << in_sel;
      dec_vec_c   = '0;
      if (!dec_legal_c) begin
         dec_vec_c = (in_mode == MODE_INV) ? '1 : '0;
      end else begin
         case (in_mode)
            MODE_ONEHOT: dec_vec_c = dec_one_c;
            // shifting out the top bit yields 0, and 0 - 1 = all ones
            MODE_THERMO: dec_vec_c = (dec_one_c << 1) - NUM_OUT'(1);
            MODE_INV:    dec_vec_c = ~dec_one_c;
            default:     dec_vec_c = '0;
         endcase
      end
   end

   // Occupancy FSM, storage update and registered output staging
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      mem_vec_d   = mem_vec_q;
      mem_err_d   = mem_err_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_vec_d   = out_vec_q;
      out_err_d   = out_err_q;

      case (state_q)
         S_EMPTY: begin
            if (push_c) state_d = S_ONE;
         end
         S_ONE: begin
            if (push_c && !pop_c)      state_d = S_FULL;
            else if (!push_c && pop_c) state_d = S_EMPTY;
         end
         S_FULL: begin
            if (pop_c) state_d = S_ONE;
         end
         default: state_d = S_EMPTY;
      endcase

      if (push_c) begin
         mem_vec_d[wr_ptr_q] = dec_vec_c;
         mem_err_d[wr_ptr_q] = !dec_legal_c;
         wr_ptr_d            = ~wr_ptr_q;
      end
      if (pop_c) begin
         rd_ptr_d = ~rd_ptr_q;
      end

      in_ready_d  = (state_d != S_FULL);
      out_valid_d = (state_d != S_EMPTY);
      if (out_valid_d) begin
         out_vec_d = mem_vec_d[rd_ptr_d];
         out_err_d = mem_err_d[rd_ptr_d];
      end else begin
         out_vec_d = '0;
         out_err_d = 1'b0;
      end
   end

   // Error flag and saturating counter; clear wins over a same-cycle increment
   always_comb begin
      err_sticky_d = err_sticky_q;
      err_count_d  = err_count_q;
      if (err_clr) begin
         err_sticky_d = 1'b0;
         err_count_d  = '0;
      end else if (push_c && !dec_legal_c) begin
         err_sticky_d = 1'b1;
         if (err_count_q != '1) begin
            err_count_d = err_count_q + CNT_W'(1);
         end
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_EMPTY;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         mem_vec_q[0] <= '0;
         mem_vec_q[1] <= '0;
         mem_err_q[0] <= 1'b0;
         mem_err_q[1] <= 1'b0;
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
         out_vec_q    <= '0;
         out_err_q    <= 1'b0;
         err_sticky_q <= 1'b0;
         err_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         mem_vec_q[0] <= mem_vec_d[0];
         mem_vec_q[1] <= mem_vec_d[1];
         mem_err_q[0] <= mem_err_d[0];
         mem_err_q[1] <= mem_err_d[1];
         in_ready_q   <= in_ready_d;
         out_valid_q  <= out_valid_d;
         out_vec_q    <= out_vec_d;
         out_err_q    <= out_err_d;
         err_sticky_q <= err_sticky_d;
         err_count_q  <= err_count_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign out_vec    = out_vec_q;
   assign out_err    = out_err_q;
   assign err_sticky = err_sticky_q;
   assign err_count  = err_count_q;

endmodule

// File: tb/tb_decoder_pipe.sv
// Bench for decoder_pipe: a default instance (32 outputs, 8-bit counter) and a
// narrow instance (20 outputs, 2-bit counter) share one stimulus stream.
module tb_decoder_pipe;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        out_ready;
   logic        err_clr;
   logic [4:0]  in_sel;
   logic [1:0]  in_mode;

   logic        a_in_ready, a_out_valid, a_out_err, a_err_sticky;
   logic [31:0] a_out_vec;
   logic [7:0]  a_err_count;
   logic        b_in_ready, b_out_valid, b_out_err, b_err_sticky;
   logic [19:0] b_out_vec;
   logic [1:0]  b_err_count;

   int n_vec = 0;
   int n_err = 0;

   // reference model: queue of raw {mode, sel} transactions plus error state
   logic [6:0] mq[$];
   int         a_cnt = 0, b_cnt = 0;
   bit         a_stk = 0, b_stk = 0;

   decoder_pipe #(.SEL_W(5), .NUM_OUT(32), .CNT_W(8)) dut_a (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_sel(in_sel), .in_mode(in_mode), .out_valid(a_out_valid),
      .out_ready(out_ready), .out_vec(a_out_vec), .out_err(a_out_err),
      .err_sticky(a_err_sticky), .err_count(a_err_count), .err_clr(err_clr));

   decoder_pipe #(.SEL_W(5), .NUM_OUT(20), .CNT_W(2)) dut_b (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_sel(in_sel), .in_mode(in_mode), .out_valid(b_out_valid),
      .out_ready(out_ready), .out_vec(b_out_vec), .out_err(b_out_err),
      .err_sticky(b_err_sticky), .err_count(b_err_count), .err_clr(err_clr));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit is_illegal(logic [4:0] sel, logic [1:0] mode, int n);
      return (int'(sel) >= n) || (mode == 2'b11);
   endfunction

   // expected decoded word for an n-output decoder
   function automatic logic [31:0] exp_vec(logic [4:0] sel, logic [1:0] mode, int n);
      logic [63:0] mask, bit_v, r;
      mask  = (64'd1 << n) - 64'd1;
      bit_v = 64'd1 << sel;
      if (is_illegal(sel, mode, n)) r = (mode == 2'b10) ? mask : 64'd0;
      else if (mode == 2'b00)       r = bit_v;
      else if (mode == 2'b01)       r = (bit_v << 1) - 64'd1;
      else                          r = ~bit_v & mask;
      return r[31:0];
   endfunction

   // advance one clock and update the model with what was transferred
   task automatic step();
      bit push, pop, clr;
      logic [6:0] e;
      push = in_valid && (mq.size() < 2);
      pop  = out_ready && (mq.size() > 0);
      clr  = err_clr;
      e    = {in_mode, in_sel};
      @(posedge clk);
      #1;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(e);
      if (clr) begin
         a_cnt = 0; b_cnt = 0; a_stk = 0; b_stk = 0;
      end else if (push) begin
         if (is_illegal(e[4:0], e[6:5], 32)) begin
            a_stk = 1; if (a_cnt < 255) a_cnt++;
         end
         if (is_illegal(e[4:0], e[6:5], 20)) begin
            b_stk = 1; if (b_cnt < 3) b_cnt++;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1; in_valid = 0; out_ready = 0; err_clr = 0; in_sel = '0; in_mode = '0;
      #3;
      n_vec++; if (a_in_ready !== 1'b1)   begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", a_in_ready); end
      n_vec++; if (a_out_valid !== 1'b0)  begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); end
      n_vec++; if (a_out_vec !== 32'h0)   begin n_err++; $display("FAIL reset_out_vec got=%h exp=0", a_out_vec); end
      n_vec++; if (a_out_err !== 1'b0)    begin n_err++; $display("FAIL reset_out_err got=%b exp=0", a_out_err); end
      n_vec++; if (a_err_sticky !== 1'b0) begin n_err++; $display("FAIL reset_sticky got=%b exp=0", a_err_sticky); end
      n_vec++; if (a_err_count !== 8'h0)  begin n_err++; $display("FAIL reset_count got=%h exp=0", a_err_count); end
      n_vec++; if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0)
         begin n_err++; $display("FAIL reset_b_hs got=%b%b exp=10", b_in_ready, b_out_valid); end
      @(negedge clk);
      reset = 0;
   endtask

   task automatic test_onehot();
      in_valid = 1; in_sel = 5'd5; in_mode = 2'b00; out_ready = 1;
      step();
      in_valid = 0;
      n_vec++; if (a_out_valid !== 1'b1)  begin n_err++; $display("FAIL onehot_valid got=%b exp=1", a_out_valid); end
      n_vec++; if (a_out_vec !== 32'h0000_0020) begin n_err++; $display("FAIL onehot_vec got=%h exp=00000020", a_out_vec); end
      n_vec++; if (a_out_err !== 1'b0)    begin n_err++; $display("FAIL onehot_err got=%b exp=0", a_out_err); end
      n_vec++; if (b_out_vec !== 20'h00020) begin n_err++; $display("FAIL onehot_b_vec got=%h exp=00020", b_out_vec); end
   endtask

   task automatic test_thermo_inv();
      in_valid = 1; in_sel = 5'd3; in_mode = 2'b01;
      step();
      n_vec++; if (a_out_vec !== 32'h0000_000F) begin n_err++; $display("FAIL thermo_vec got=%h exp=0000000f", a_out_vec); end
      in_mode = 2'b10;
      step();
      in_valid = 0;
      n_vec++; if (a_out_vec !== 32'hFFFF_FFF7) begin n_err++; $display("FAIL inv_vec got=%h exp=fffffff7", a_out_vec); end
      n_vec++; if (b_out_vec !== 20'hFFFF7) begin n_err++; $display("FAIL inv_b_vec got=%h exp=ffff7", b_out_vec); end
   endtask

   task automatic test_illegal_clr();
      in_valid = 1; in_sel = 5'd25; in_mode = 2'b00;
      step();
      in_valid = 0;
      n_vec++; if (b_out_vec !== 20'h0) begin n_err++; $display("FAIL illegal_vec got=%h exp=0", b_out_vec); end
      n_vec++; if (b_out_err !== 1'b1)  begin n_err++; $display("FAIL illegal_err got=%b exp=1", b_out_err); end
      n_vec++; if (b_err_sticky !== 1'b1) begin n_err++; $display("FAIL illegal_sticky got=%b exp=1", b_err_sticky); end
      n_vec++; if (b_err_count !== 2'd1) begin n_err++; $display("FAIL illegal_count got=%0d exp=1", b_err_count); end
      n_vec++; if (a_out_vec !== 32'h0200_0000 || a_out_err !== 1'b0)
         begin n_err++; $display("FAIL legal25_a got=%h/%b exp=02000000/0", a_out_vec, a_out_err); end
      err_clr = 1;
      step();
      err_clr = 0;
      n_vec++; if (b_err_sticky !== 1'b0 || b_err_count !== 2'd0)
         begin n_err++; $display("FAIL clr got=%b/%0d exp=0/0", b_err_sticky, b_err_count); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] got[$];
      logic [31:0] exp_l [3];
      bit sent;
      exp_l[0] = 32'h2; exp_l[1] = 32'h4; exp_l[2] = 32'h8;
      out_ready = 0; in_valid = 1; in_mode = 2'b00;
      in_sel = 5'd1; step();
      in_sel = 5'd2; step();
      in_sel = 5'd3;
      n_vec++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full got=%b exp=0", a_in_ready); end
      step(); step();
      n_vec++; if (a_out_vec !== 32'h2 || a_out_valid !== 1'b1)
         begin n_err++; $display("FAIL b2b_hold got=%h/%b exp=2/1", a_out_vec, a_out_valid); end
      out_ready = 1;
      for (int c = 0; c < 10 && got.size() < 3; c++) begin
         sent = in_valid && (mq.size() < 2);
         if (a_out_valid && out_ready) got.push_back(a_out_vec);
         step();
         if (sent) in_valid = 0;
      end
      n_vec++; if (got.size() != 3) begin n_err++; $display("FAIL b2b_count got=%0d exp=3", got.size()); end
      for (int k = 0; k < 3; k++) begin
         n_vec++;
         if (k >= got.size()) begin n_err++; $display("FAIL b2b_word%0d got=none exp=%h", k, exp_l[k]); end
         else if (got[k] !== exp_l[k]) begin n_err++; $display("FAIL b2b_word%0d got=%h exp=%h", k, got[k], exp_l[k]); end
      end
   endtask

   task automatic test_saturate();
      out_ready = 1; in_valid = 1; in_mode = 2'b11;
      for (int k = 0; k < 5; k++) begin
         in_sel = 5'($urandom_range(0, 31));
         step();
      end
      in_valid = 0;
      step();
      n_vec++; if (b_err_count !== 2'd3) begin n_err++; $display("FAIL sat_b_count got=%0d exp=3", b_err_count); end
      n_vec++; if (a_err_count !== 8'd5) begin n_err++; $display("FAIL sat_a_count got=%0d exp=5", a_err_count); end
      n_vec++; if (a_err_sticky !== 1'b1) begin n_err++; $display("FAIL sat_sticky got=%b exp=1", a_err_sticky); end
   endtask

   task automatic test_reset_mid();
      out_ready = 0; in_valid = 1; in_mode = 2'b00;
      in_sel = 5'd4; step();
      in_sel = 5'd9; step();
      in_valid = 0;
      n_vec++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1)
         begin n_err++; $display("FAIL mid_full got=%b%b exp=01", a_in_ready, a_out_valid); end
      #2 reset = 1;
      #1;
      mq.delete(); a_cnt = 0; b_cnt = 0; a_stk = 0; b_stk = 0;
      n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid got=%b exp=0", a_out_valid); end
      n_vec++; if (a_in_ready !== 1'b1)  begin n_err++; $display("FAIL mid_ready got=%b exp=1", a_in_ready); end
      n_vec++; if (b_err_count !== 2'd0 || a_err_count !== 8'd0)
         begin n_err++; $display("FAIL mid_count got=%0d/%0d exp=0/0", a_err_count, b_err_count); end
      @(negedge clk);
      reset = 0;
      // first edge after release must accept
      in_valid = 1; in_sel = 5'd7; in_mode = 2'b00; out_ready = 1;
      step();
      in_valid = 0;
      n_vec++; if (a_out_valid !== 1'b1 || a_out_vec !== 32'h80)
         begin n_err++; $display("FAIL post_reset got=%b/%h exp=1/00000080", a_out_valid, a_out_vec); end
   endtask

   task automatic test_random();
      logic [31:0] ea, eb;
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         err_clr   = ($urandom_range(0, 31) == 0);
         in_sel    = 5'($urandom_range(0, 31));
         in_mode   = 2'($urandom_range(0, 3));
         step();
         n_vec++; if (a_out_valid !== (mq.size() > 0) || b_out_valid !== (mq.size() > 0))
            begin n_err++; $display("FAIL rnd_valid c=%0d got=%b%b exp=%0d", c, a_out_valid, b_out_valid, mq.size() > 0); end
         n_vec++; if (a_in_ready !== (mq.size() < 2) || b_in_ready !== (mq.size() < 2))
            begin n_err++; $display("FAIL rnd_ready c=%0d got=%b%b exp=%0d", c, a_in_ready, b_in_ready, mq.size() < 2); end
         if (mq.size() > 0) begin
            ea = exp_vec(mq[0][4:0], mq[0][6:5], 32);
            eb = exp_vec(mq[0][4:0], mq[0][6:5], 20);
            n_vec++; if (a_out_vec !== ea || a_out_err !== is_illegal(mq[0][4:0], mq[0][6:5], 32))
               begin n_err++; $display("FAIL rnd_a_word c=%0d got=%h/%b exp=%h", c, a_out_vec, a_out_err, ea); end
            n_vec++; if (b_out_vec !== eb[19:0] || b_out_err !== is_illegal(mq[0][4:0], mq[0][6:5], 20))
               begin n_err++; $display("FAIL rnd_b_word c=%0d got=%h/%b exp=%h", c, b_out_vec, b_out_err, eb[19:0]); end
         end
         n_vec++; if (a_err_sticky !== a_stk || int'(a_err_count) != a_cnt)
            begin n_err++; $display("FAIL rnd_a_err c=%0d got=%b/%0d exp=%b/%0d", c, a_err_sticky, a_err_count, a_stk, a_cnt); end
         n_vec++; if (b_err_sticky !== b_stk || int'(b_err_count) != b_cnt)
            begin n_err++; $display("FAIL rnd_b_err c=%0d got=%b/%0d exp=%b/%0d", c, b_err_sticky, b_err_count, b_stk, b_cnt); end
      end
      in_valid = 0; err_clr = 0;
   endtask

   initial begin
      test_reset();
      test_onehot();
      test_thermo_inv();
      test_illegal_clr();
      test_back_to_back();
      test_saturate();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
